basilisk_reg_scoreboard: RTL and testbench

- Per-register status tracker for the Basilisk FP/vector register file (32 entries).
- Produces the 32-entry register-status vector consumed by the decode dependency check.
- Issue marks a destination busy and records its kind; writebacks from the execute pipeline and the load path retire it.
- Sits beside decode; is updated by issue and by writeback.

---
 rtl/basilisk.sv | 8 +
 rtl/basilisk_decode_util.sv | 12 +
 rtl/basilisk_reg_scoreboard_pkg.sv | 13 +
 rtl/basilisk_reg_scoreboard_if.sv | 34 +++
 rtl/basilisk_reg_scoreboard_counter.sv | 50 +++++
 rtl/basilisk_reg_scoreboard.sv | 78 +++++++
 tb/tb_basilisk_reg_scoreboard.sv | 207 ++++++++++++++++++++
 7 files changed

// File: rtl/basilisk.sv
// Shared Basilisk core constants and types.
package basilisk;

    localparam int BASILISK_NUM_FREGS = 32;

    typedef logic [4:0] basilisk_freg_idx_t;

endpackage

// File: rtl/basilisk_decode_util.sv
// Shared decode helpers: the per-register status encoding that decode's
// dependency check consumes. VALID means no outstanding write.
package basilisk_decode_util;

    typedef enum logic [1:0] {
        VALID     = 2'd0,
        INVALID   = 2'd1,
        SLIDEUP   = 2'd2,
        SLIDEDOWN = 2'd3
    } basilisk_decode_reg_status_t;

endpackage

// File: rtl/basilisk_reg_scoreboard_pkg.sv
// Scoreboard-local defaults and helpers for basilisk_reg_scoreboard.
package basilisk_reg_scoreboard_pkg;
    import basilisk_decode_util::*;

    localparam int SB_NUM_REGS   = basilisk::BASILISK_NUM_FREGS;
    localparam int SB_PEND_WIDTH = 2;

    // VALID is reserved for "no write pending" and cannot be issued.
    function automatic logic sb_kind_legal(input basilisk_decode_reg_status_t k);
        return k != VALID;
    endfunction

endpackage

// File: rtl/basilisk_reg_scoreboard_if.sv
// Decode/writeback-facing bundle of the register scoreboard.
// master = decode/writeback side, slave = scoreboard.
interface basilisk_reg_scoreboard_if #(
    parameter int NUM_REGS = 32
);
    import basilisk_decode_util::*;

    localparam int IDX_W = $clog2(NUM_REGS);

    logic                        issue_valid;
    logic                        issue_ready;
    logic [IDX_W-1:0]            issue_rd;
    basilisk_decode_reg_status_t issue_kind;
    logic                        wb0_valid;
    logic [IDX_W-1:0]            wb0_rd;
    logic                        wb1_valid;
    logic [IDX_W-1:0]            wb1_rd;
    logic                        flush;
    logic [2*NUM_REGS-1:0]       reg_status;
    logic                        busy;
    logic                        error;

    modport master (
        output issue_valid, issue_rd, issue_kind,
        output wb0_valid, wb0_rd, wb1_valid, wb1_rd, flush,
        input  issue_ready, reg_status, busy, error
    );

    modport slave (
        input  issue_valid, issue_rd, issue_kind,
        input  wb0_valid, wb0_rd, wb1_valid, wb1_rd, flush,
        output issue_ready, reg_status, busy, error
    );
endinterface

// File: rtl/basilisk_reg_scoreboard_counter.sv
// basilisk_reg_pending_counter: outstanding-write count and latest kind for
// one register. Net update is +inc -dec0 -dec1, clamped at zero.
module basilisk_reg_pending_counter
    import basilisk_decode_util::*;
#(
    parameter int PEND_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        inc,
    input  logic                        dec0,
    input  logic                        dec1,
    input  logic                        flush,
    input  basilisk_decode_reg_status_t kind_in,
    output logic [PEND_WIDTH-1:0]       cnt,
    output basilisk_decode_reg_status_t kind,
    output logic                        underflow
);
    logic [PEND_WIDTH-1:0]       cnt_reg, cnt_next;
    basilisk_decode_reg_status_t kind_reg, kind_next;
    logic [PEND_WIDTH+1:0]       up, dn, diff;

    always_comb begin
        up        = {2'b00, cnt_reg} + {{(PEND_WIDTH+1){1'b0}}, inc};
        dn        = {{(PEND_WIDTH+1){1'b0}}, dec0} + {{(PEND_WIDTH+1){1'b0}}, dec1};
        diff      = up - dn;
        underflow = (up < dn) && !flush;
        cnt_next  = diff[PEND_WIDTH-1:0];
        kind_next = inc ? kind_in : kind_reg;
        if (flush) begin
            cnt_next  = '0;
            kind_next = VALID;
        end else if (up < dn) begin
            cnt_next  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg  <= '0;
            kind_reg <= VALID;
        end else begin
            cnt_reg  <= cnt_next;
            kind_reg <= kind_next;
        end
    end

    assign cnt  = cnt_reg;
    assign kind = kind_reg;
endmodule

// File: rtl/basilisk_reg_scoreboard.sv
// Per-register write-pending scoreboard for the FP/vector register file.
// Optional BASILISK_SCOREBOARD_BYPASS_EN: same-cycle writebacks show on reg_status/issue_ready.
module basilisk_reg_scoreboard
    import basilisk_decode_util::*;
    import basilisk_reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS   = SB_NUM_REGS,
    parameter int PEND_WIDTH = SB_PEND_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    basilisk_reg_scoreboard_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [PEND_WIDTH-1:0] CNT_MAX = '1;

    logic                        issue_fire;
    basilisk_decode_reg_status_t kind_in;
    logic [PEND_WIDTH-1:0]       cnt      [NUM_REGS];
    logic [PEND_WIDTH-1:0]       cnt_view [NUM_REGS];
    basilisk_decode_reg_status_t kind     [NUM_REGS];
    logic [NUM_REGS-1:0]         underflow;
    logic [NUM_REGS-1:0]         pending;
    logic [2*NUM_REGS-1:0]       status_vec;
    logic                        error_reg;

    assign issue_fire = bus.issue_valid && bus.issue_ready;
    // An illegal VALID issue is still tracked, but as INVALID so decode stalls.
    assign kind_in = sb_kind_legal(bus.issue_kind) ? bus.issue_kind : INVALID;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic inc, dec0, dec1;
            assign inc  = issue_fire    && (bus.issue_rd == IDX_W'(gi));
            assign dec0 = bus.wb0_valid && (bus.wb0_rd   == IDX_W'(gi));
            assign dec1 = bus.wb1_valid && (bus.wb1_rd   == IDX_W'(gi));

            basilisk_reg_pending_counter #(.PEND_WIDTH(PEND_WIDTH)) u_cnt (
                .clk       (clk),
                .rst       (rst),
                .inc       (inc),
                .dec0      (dec0),
                .dec1      (dec1),
                .flush     (bus.flush),
                .kind_in   (kind_in),
                .cnt       (cnt[gi]),
                .kind      (kind[gi]),
                .underflow (underflow[gi])
            );

`ifdef BASILISK_SCOREBOARD_BYPASS_EN
            logic [PEND_WIDTH:0] dsum;
            logic [PEND_WIDTH:0] post;
            assign dsum = {{PEND_WIDTH{1'b0}}, dec0} + {{PEND_WIDTH{1'b0}}, dec1};
            assign post = {1'b0, cnt[gi]} - dsum;
            assign cnt_view[gi] = ({1'b0, cnt[gi]} >= dsum) ? post[PEND_WIDTH-1:0] : '0;
`else
            assign cnt_view[gi] = cnt[gi];
`endif

            assign status_vec[2*gi +: 2] = (cnt_view[gi] == '0) ? VALID : kind[gi];
            assign pending[gi]           = (cnt[gi] != '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            error_reg <= 1'b0;
        end else if ((|underflow) || (issue_fire && !sb_kind_legal(bus.issue_kind))) begin
            error_reg <= 1'b1;
        end
    end

    assign bus.issue_ready = !bus.flush && (cnt_view[bus.issue_rd] != CNT_MAX);
    assign bus.reg_status  = status_vec;
    assign bus.busy        = |pending;
    assign bus.error       = error_reg;
endmodule

// File: tb/tb_basilisk_reg_scoreboard.sv
// Directed-vector bench for basilisk_reg_scoreboard; expectations adapt to
// BASILISK_SCOREBOARD_BYPASS_EN.
module tb_basilisk_reg_scoreboard;
    import basilisk_decode_util::*;

`ifdef BASILISK_SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    basilisk_reg_scoreboard_if #(.NUM_REGS(32)) bus ();

    basilisk_reg_scoreboard #(.NUM_REGS(32), .PEND_WIDTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.issue_kind  = INVALID;
        bus.wb0_valid   = 1'b0;
        bus.wb0_rd      = '0;
        bus.wb1_valid   = 1'b0;
        bus.wb1_rd      = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic issue(input int rd, input basilisk_decode_reg_status_t k);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'(rd);
        bus.issue_kind  = k;
    endtask

    function automatic logic [1:0] st(input int r);
        return bus.reg_status[2*r +: 2];
    endfunction

    initial begin
        idle();

        // reset
        rst = 1'b0;
        step();
        step();
        check_vec("rst_status", bus.reg_status, 64'h0);
        check_vec("rst_busy",   bus.busy, 0);
        check_vec("rst_ready",  bus.issue_ready, 1);
        check_vec("rst_error",  bus.error, 0);
        rst = 1'b1;
        step();

        // single issue then writeback on r5
        issue(5, SLIDEUP);
        #1 check_vec("r5_ready", bus.issue_ready, 1);
        step();
        idle();
        check_vec("r5_status_c1", st(5), SLIDEUP);
        check_vec("r5_busy",      bus.busy, 1);
        step();
        check_vec("r5_status_c2", st(5), SLIDEUP);
        bus.wb0_valid = 1'b1;
        bus.wb0_rd    = 5'd5;
        #1 check_vec("r5_wb_same_cycle", st(5), BYP ? 2'd0 : 2'd2);
        step();
        idle();
        check_vec("r5_status_done", st(5), VALID);
        check_vec("r5_busy_done",   bus.busy, 0);

        // saturate r7
        issue(7, INVALID);
        step();
        step();
        #1 check_vec("r7_ready_at2", bus.issue_ready, 1);
        step();
        check_vec("r7_ready_full", bus.issue_ready, 0);
        step();
        check_vec("r7_status_full", st(7), INVALID);
        check_vec("r7_ready_held",  bus.issue_ready, 0);
        bus.issue_valid = 1'b0;
        bus.wb1_valid   = 1'b1;
        bus.wb1_rd      = 5'd7;
        #1 check_vec("r7_ready_wb_cycle", bus.issue_ready, BYP ? 1 : 0);
        step();
        bus.wb1_valid = 1'b0;
        #1 check_vec("r7_ready_after_wb", bus.issue_ready, 1);
        check_vec("r7_status_after_wb", st(7), INVALID);
        bus.wb0_valid = 1'b1;
        bus.wb0_rd    = 5'd7;
        bus.wb1_valid = 1'b1;
        bus.wb1_rd    = 5'd7;
        step();
        idle();
        check_vec("r7_dual_wb_status", st(7), VALID);
        check_vec("r7_dual_wb_error",  bus.error, 0);

        // same-cycle issue+wb on r3, then double underflow
        issue(3, SLIDEUP);
        step();
        bus.issue_kind = SLIDEDOWN;
        bus.wb0_valid  = 1'b1;
        bus.wb0_rd     = 5'd3;
        #1 check_vec("r3_ready", bus.issue_ready, 1);
        step();
        bus.issue_valid = 1'b0;
        bus.wb1_valid   = 1'b1;
        bus.wb1_rd      = 5'd3;
        #1 check_vec("r3_kind_updated", st(3), BYP ? 2'd0 : 2'd3);
        check_vec("r3_busy", bus.busy, 1);
        check_vec("r3_error_pre", bus.error, 0);
        step();
        idle();
        check_vec("r3_status_underflow", st(3), VALID);
        check_vec("r3_error_underflow",  bus.error, 1);
        check_vec("r3_busy_underflow",   bus.busy, 0);

        // flush with simultaneous issue
        issue(1, SLIDEUP);
        step();
        issue(2, SLIDEDOWN);
        step();
        issue(9, INVALID);
        step();
        idle();
        check_vec("pre_flush_r1", st(1), SLIDEUP);
        check_vec("pre_flush_r2", st(2), SLIDEDOWN);
        check_vec("pre_flush_r9", st(9), INVALID);
        bus.flush = 1'b1;
        issue(4, SLIDEUP);
        #1 check_vec("flush_ready", bus.issue_ready, 0);
        step();
        idle();
        check_vec("flush_status", bus.reg_status, 64'h0);
        check_vec("flush_busy",   bus.busy, 0);
        check_vec("flush_error_sticky", bus.error, 1);

        // bypass latency on r10
        issue(10, SLIDEUP);
        step();
        idle();
        bus.wb0_valid = 1'b1;
        bus.wb0_rd    = 5'd10;
        #1 check_vec("r10_wb_same_cycle", st(10), BYP ? 2'd0 : 2'd2);
        step();
        idle();
        check_vec("r10_after_wb", st(10), VALID);

        // reset mid-operation, then stale writeback
        issue(20, INVALID);
        step();
        idle();
        check_vec("r20_busy", bus.busy, 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_vec("mid_rst_status", bus.reg_status, 64'h0);
        check_vec("mid_rst_busy",   bus.busy, 0);
        check_vec("mid_rst_error",  bus.error, 0);
        bus.wb1_valid = 1'b1;
        bus.wb1_rd    = 5'd20;
        step();
        idle();
        check_vec("stale_wb_error", bus.error, 1);
        check_vec("stale_wb_r20",   st(20), VALID);

        // illegal issue kind
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_vec("rst2_error", bus.error, 0);
        issue(12, VALID);
        step();
        idle();
        bus.issue_rd = 5'd12;
        #1 check_vec("illegal_status", st(12), INVALID);
        check_vec("illegal_error",  bus.error, 1);
        check_vec("illegal_busy",   bus.busy, 1);
        check_vec("illegal_ready",  bus.issue_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
